// File: rtl/spi_pkg.sv
// Shared defaults, master state encoding and counter sizing for the SPI link.
package spi_pkg;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_CLK_DIV = 4;

    // Master engine states, kept as plain constants for legacy tools.
    typedef logic [2:0] mst_state_t;
    localparam mst_state_t ST_IDLE  = 3'd0;
    localparam mst_state_t ST_SETUP = 3'd1;
    localparam mst_state_t ST_HIGH  = 3'd2;
    localparam mst_state_t ST_LOW   = 3'd3;
    localparam mst_state_t ST_DONE  = 3'd4;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_master_slave_slave_core.sv
// SPI mode-0 slave: edge detection on the registered sclk/cs_n, shift registers
// and a completion pulse for full-length words only.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] s_tx_data,
    output logic [DATA_W-1:0] s_rx_data,
    output logic              s_rx_valid
);

    localparam int BW = cnt_width(DATA_W);
    localparam logic [BW-1:0] FULL_CNT = BW'(DATA_W);

    logic              sclk_q;
    logic              cs_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [BW-1:0]     bit_cnt;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_rise;

    assign sclk_rise = sclk & ~sclk_q;
    assign sclk_fall = ~sclk & sclk_q;
    assign cs_rise   = cs_n & ~cs_q;

    // miso carries no data while deselected; otherwise the current MSB.
    assign miso = cs_n ? 1'b0 : tx_sr[DATA_W-1];

    // Delayed copies of the bus lines for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b0;
        end else begin
            sclk_q <= sclk;
            cs_q   <= cs_n;
        end
    end

    // Shift engine: reload while deselected, sample on rise, advance on fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (cs_n) begin
            tx_sr   <= s_tx_data;
            bit_cnt <= '0;
        end else begin
            if (sclk_rise) begin
                rx_sr   <= {rx_sr[DATA_W-2:0], mosi};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Publish the word when chip select releases after exactly DATA_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rx_data  <= '0;
            s_rx_valid <= 1'b0;
        end else if (cs_rise && (bit_cnt == FULL_CNT)) begin
            s_rx_data  <= rx_sr;
            s_rx_valid <= 1'b1;
        end else begin
            s_rx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_master_slave.sv
// SPI mode-0 master engine wired to a matching slave on one clock; all SPI
// wires are exported so the pair can be observed or reused on a board.
module spi_master_slave
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] m_tx_data,
    output logic [DATA_W-1:0] m_rx_data,
    output logic              done,
    output logic              busy,
    input  logic [DATA_W-1:0] s_tx_data,
    output logic [DATA_W-1:0] s_rx_data,
    output logic              s_rx_valid,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    output logic              miso
);

    localparam int BW = cnt_width(DATA_W);
    localparam int DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0] FULL_CNT = BW'(DATA_W);

    mst_state_t        state;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              div_end;

    assign div_end = (div_cnt == DIV_LAST);

    // Master sequencer: every phase lasts CLK_DIV cycles; sclk, mosi and the
    // miso sample all change on the edge that enters the next phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            m_rx_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sr   <= m_tx_data;
                        mosi    <= m_tx_data[DATA_W-1];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        rx_sr   <= {rx_sr[DATA_W-2:0], miso};
                        state   <= ST_HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                        tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
                        // After the final bit mosi simply holds until release.
                        if (bit_cnt != LAST_BIT) begin
                            mosi <= tx_sr[DATA_W-2];
                        end
                        state   <= ST_LOW;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == FULL_CNT) begin
                            cs_n      <= 1'b1;
                            mosi      <= 1'b0;
                            m_rx_data <= rx_sr;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[DATA_W-2:0], miso};
                            state <= ST_HIGH;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // busy stays up through the done cycle; start here is dropped.
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    spi_slave_core #(
        .DATA_W (DATA_W)
    ) u_slave (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso),
        .s_tx_data  (s_tx_data),
        .s_rx_data  (s_rx_data),
        .s_rx_valid (s_rx_valid)
    );

endmodule

// File: tb/tb_spi_master_slave.sv
// Bench for the SPI master/slave pair: directed and random exchanges checked
// against a swap model (master receives the slave word and vice versa).
module tb_spi_master_slave;

    localparam int W       = 8;
    localparam int DIV     = 4;
    localparam int LATENCY = DIV + 2 * DIV * W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] m_tx_data = '0;
    logic [W-1:0] m_rx_data;
    logic         done;
    logic         busy;
    logic [W-1:0] s_tx_data = '0;
    logic [W-1:0] s_rx_data;
    logic         s_rx_valid;
    logic         sclk;
    logic         cs_n;
    logic         mosi;
    logic         miso;

    int n_checks = 0;
    int n_fail   = 0;
    int done_tot = 0;
    int valid_tot = 0;
    int rise_tot = 0;
    logic sclk_prev = 1'b0;
    logic mosi_prev = 1'b0;

    spi_master_slave #(
        .DATA_W  (W),
        .CLK_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .m_tx_data  (m_tx_data),
        .m_rx_data  (m_rx_data),
        .done       (done),
        .busy       (busy),
        .s_tx_data  (s_tx_data),
        .s_rx_data  (s_rx_data),
        .s_rx_valid (s_rx_valid),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .miso       (miso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: pulse/edge tallies and per-cycle waveform rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_tot++;
            if (s_rx_valid) valid_tot++;
            if (sclk && !sclk_prev && !cs_n) begin
                rise_tot++;
                check("mosi_stable_at_rise", mosi, mosi_prev);
            end
            if (cs_n) check("sclk_idle_when_deselected", sclk, 1'b0);
        end
        sclk_prev = sclk;
        mosi_prev = mosi;
    end

    task automatic check_cleared(input string tag);
        check({tag, "_sclk"}, sclk, 1'b0);
        check({tag, "_cs_n"}, cs_n, 1'b1);
        check({tag, "_mosi"}, mosi, 1'b0);
        check({tag, "_miso"}, miso, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_m_rx"}, m_rx_data, '0);
        check({tag, "_s_rx"}, s_rx_data, '0);
        check({tag, "_s_valid"}, s_rx_valid, 1'b0);
    endtask

    // One exchange; expected results come from the swap model. poke_busy>0
    // pulses a conflicting start at that cycle, poke_done pulses one in the
    // done cycle. Returns one cycle after done, with start low.
    task automatic xfer(input logic [W-1:0] mt, input logic [W-1:0] st,
                        input int poke_busy, input bit poke_done);
        int k;
        int d0;
        int v0;
        int r0;
        bit got;
        d0 = done_tot;
        v0 = valid_tot;
        r0 = rise_tot;
        m_tx_data = mt;
        s_tx_data = st;
        start = 1'b1;
        k = 0;
        got = 1'b0;
        while (!got && k < 4 * LATENCY) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                check("busy_after_start", busy, 1'b1);
                check("cs_low_after_start", cs_n, 1'b0);
            end
            if (poke_busy > 0 && k == poke_busy) begin
                start = 1'b1;
                m_tx_data = ~mt;
            end else if (poke_busy > 0 && k == poke_busy + 1) begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                check("busy_in_done_cycle", busy, 1'b1);
            end
        end
        check("done_latency", k, LATENCY);
        if (poke_done) begin
            start = 1'b1;
            m_tx_data = ~mt;
        end
        @(negedge clk);
        start = 1'b0;
        check("s_rx_valid_pulse", s_rx_valid, 1'b1);
        check("busy_clear_after_done", busy, 1'b0);
        check("cs_high_between", cs_n, 1'b1);
        check("m_rx_data", m_rx_data, st);
        check("s_rx_data", s_rx_data, mt);
        #1;
        check("done_pulse_count", done_tot - d0, 1);
        check("valid_pulse_count", valid_tot - v0, 1);
        check("sclk_rise_count", rise_tot - r0, W);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int v0;
        logic [W-1:0] mt;
        logic [W-1:0] st;

        // Reset state.
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_cleared("idle");

        // Basic exchange and bit order.
        xfer(8'hA5, 8'h3C, 0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("m_rx_hold", m_rx_data, 8'h3C);
        check("s_rx_hold", s_rx_data, 8'hA5);
        xfer(8'h80, 8'h01, 0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        xfer(8'hFF, 8'h00, 0, 1'b0);
        repeat (2) @(negedge clk);
        #1;

        // Back-to-back: the second start lands the cycle after done.
        xfer(8'hB2, 8'h4D, 0, 1'b0);
        xfer(8'h7E, 8'hE7, 0, 1'b0);
        repeat (2) @(negedge clk);
        #1;

        // Start while busy, then start during the done cycle: both dropped.
        xfer(8'h96, 8'h69, 20, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("no_start_from_done_cycle", busy, 1'b0);

        // Reset mid-transfer.
        d0 = done_tot;
        v0 = valid_tot;
        m_tx_data = 8'h33;
        s_tx_data = 8'hCC;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        check_cleared("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("midreset_no_done", done_tot - d0, 0);
        check("midreset_no_valid", valid_tot - v0, 0);
        check("midreset_idle", busy, 1'b0);
        xfer(8'h5A, 8'hC3, 0, 1'b0);

        // Random exchanges with random idle gaps.
        for (int i = 0; i < 8; i++) begin
            mt = W'($urandom_range(0, 255));
            st = W'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            xfer(mt, st, 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
